// File: rtl/mem_io_if.sv
// LC-3 memory/IO access bus between the control FSM (master) and mem_io_ctrl (slave).
interface mem_io_if;
    logic        MIO_EN;
    logic        R_W;
    logic [15:0] MAR;
    logic        PSR_15;
    logic [1:0]  INMUX_SEL;
    logic        MEM_EN;
    logic        MEM_WE;
    logic        LD_KBSR;
    logic        LD_DSR;
    logic        LD_DDR;
    logic        RD_KBDR;
    logic        R;
    logic        ACV;

    modport master (
        output MIO_EN, R_W, MAR, PSR_15,
        input  INMUX_SEL, MEM_EN, MEM_WE, LD_KBSR, LD_DSR, LD_DDR, RD_KBDR, R, ACV
    );
    modport slave (
        input  MIO_EN, R_W, MAR, PSR_15,
        output INMUX_SEL, MEM_EN, MEM_WE, LD_KBSR, LD_DSR, LD_DDR, RD_KBDR, R, ACV
    );
endinterface

// File: rtl/mem_io_ctrl.sv
// LC-3 MAR/MDR access sequencer: memory wait states, device-register strobes, R handshake.
// Optional user-mode access-control check is enabled by defining MEM_ACV_EN.
module mem_io_ctrl #(
    parameter int          MEM_LATENCY = 3,
    parameter logic [15:0] KBSR_ADDR   = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR   = 16'hFE02,
    parameter logic [15:0] DSR_ADDR    = 16'hFE04,
    parameter logic [15:0] DDR_ADDR    = 16'hFE06
) (
    input  logic     CLK,
    input  logic     RESET,
    mem_io_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_IO   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] SEL_KBDR = 2'b00;
    localparam logic [1:0] SEL_KBSR = 2'b01;
    localparam logic [1:0] SEL_DSR  = 2'b10;
    localparam logic [1:0] SEL_MEM  = 2'b11;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rw_q, rw_d;
    logic [1:0] inmux_q, inmux_d;
    logic       acv_q, acv_d;

    logic       is_dev;
    logic [1:0] sel;
    logic       acv_hit;

    always_comb begin
        is_dev = 1'b1;
        sel    = SEL_MEM;
        case (bus.MAR)
            KBDR_ADDR: sel = SEL_KBDR;
            KBSR_ADDR: sel = SEL_KBSR;
            DSR_ADDR:  sel = SEL_DSR;
            DDR_ADDR:  sel = SEL_MEM;
            default:   is_dev = 1'b0;
        endcase
    end

`ifdef MEM_ACV_EN
    assign acv_hit = bus.PSR_15 && ((bus.MAR < 16'h3000) || (bus.MAR >= 16'hFE00));
`else
    logic unused_psr;
    assign unused_psr = bus.PSR_15;
    assign acv_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        inmux_d = inmux_q;
        acv_d   = 1'b0;
        case (state_q)
            S_IDLE: if (bus.MIO_EN) begin
                if (acv_hit) begin
                    acv_d = 1'b1;
                end else begin
                    rw_d    = bus.R_W;
                    inmux_d = sel;
                    if (is_dev) begin
                        state_d = S_IO;
                    end else begin
                        state_d = S_MEM;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_MEM: begin
                if (!bus.MIO_EN)      state_d = S_IDLE;
                else if (cnt_q == 0)  state_d = S_DONE;
                else                  cnt_d   = cnt_q - 4'd1;
            end
            S_IO:    state_d = bus.MIO_EN ? S_DONE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            inmux_q <= SEL_MEM;
            acv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            inmux_q <= inmux_d;
            acv_q   <= acv_d;
        end
    end

    // Strobes are gated by MIO_EN so an abort drops them in the same cycle.
    logic mem_act, io_act;
    assign mem_act = (state_q == S_MEM) && bus.MIO_EN;
    assign io_act  = (state_q == S_IO)  && bus.MIO_EN;

    // In IO, SEL_MEM can only mean DDR.
    assign bus.INMUX_SEL = inmux_q;
    assign bus.MEM_EN    = mem_act;
    assign bus.MEM_WE    = mem_act && rw_q;
    assign bus.LD_KBSR   = io_act && rw_q  && (inmux_q == SEL_KBSR);
    assign bus.LD_DSR    = io_act && rw_q  && (inmux_q == SEL_DSR);
    assign bus.LD_DDR    = io_act && rw_q  && (inmux_q == SEL_MEM);
    assign bus.RD_KBDR   = io_act && !rw_q && (inmux_q == SEL_KBDR);
    assign bus.R         = (state_q == S_DONE);
    assign bus.ACV       = acv_q;
endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed per-cycle vector bench for mem_io_ctrl (MEM_LATENCY=3), plus a handshake latency sequence.
module tb_mem_io_ctrl;
    logic CLK = 1'b0;
    logic RESET;
    mem_io_if bus ();

    mem_io_ctrl dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, en, rw;
        logic [15:0] mar;
        logic        psr, chk;
        logic [9:0]  exp;
    } vec_t;

    vec_t vq[$];
    int n_tests = 0;
    int n_fail  = 0;

    // {INMUX_SEL, MEM_EN, MEM_WE, LD_KBSR, LD_DSR, LD_DDR, RD_KBDR, R, ACV}
    localparam logic [9:0] I11   = 10'b11_00000000;
    localparam logic [9:0] I00   = 10'b00_00000000;
    localparam logic [9:0] I01   = 10'b01_00000000;
    localparam logic [9:0] I10   = 10'b10_00000000;
    localparam logic [9:0] MEMR  = 10'b11_10000000;
    localparam logic [9:0] MEMW  = 10'b11_11000000;
    localparam logic [9:0] R11   = 10'b11_00000010;
    localparam logic [9:0] R00   = 10'b00_00000010;
    localparam logic [9:0] R01   = 10'b01_00000010;
    localparam logic [9:0] R10   = 10'b10_00000010;
    localparam logic [9:0] WDDR  = 10'b11_00001000;
    localparam logic [9:0] RKBDR = 10'b00_00000100;
    localparam logic [9:0] WKBSR = 10'b01_00100000;
    localparam logic [9:0] WDSR  = 10'b10_00010000;
    localparam logic [9:0] ACV11 = 10'b11_00000001;

    task automatic add(input logic rst, en, rw, input logic [15:0] mar,
                       input logic psr, chk, input logic [9:0] exp);
        vec_t v;
        v.rst = rst; v.en = en; v.rw = rw; v.mar = mar;
        v.psr = psr; v.chk = chk; v.exp = exp;
        vq.push_back(v);
    endtask

    function automatic logic [9:0] outs();
        return {bus.INMUX_SEL, bus.MEM_EN, bus.MEM_WE, bus.LD_KBSR, bus.LD_DSR,
                bus.LD_DDR, bus.RD_KBDR, bus.R, bus.ACV};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int n;
        RESET = 1'b1; bus.MIO_EN = 1'b0; bus.R_W = 1'b0; bus.MAR = 16'h0; bus.PSR_15 = 1'b0;

        add(1,0,0,16'h0000,0,0,I11);
        add(1,0,0,16'h0000,0,1,I11);       // reset state
        // memory read 0x3000, 3 wait states
        add(0,1,0,16'h3000,0,1,I11);
        add(0,1,0,16'h3000,0,1,MEMR);
        add(0,1,0,16'h3000,0,1,MEMR);
        add(0,1,0,16'h3000,0,1,MEMR);
        add(0,1,0,16'h3000,0,1,R11);
        add(0,0,0,16'h3000,0,1,I11);
        // DDR write
        add(0,1,1,16'hFE06,0,1,I11);
        add(0,1,1,16'hFE06,0,1,WDDR);
        add(0,1,1,16'hFE06,0,1,R11);
        add(0,0,0,16'hFE06,0,1,I11);
        // KBDR read then KBSR read with bubble
        add(0,1,0,16'hFE02,0,1,I11);
        add(0,1,0,16'hFE02,0,1,RKBDR);
        add(0,1,0,16'hFE00,0,1,R00);
        add(0,1,0,16'hFE00,0,1,I00);
        add(0,1,0,16'hFE00,0,1,I01);
        add(0,1,0,16'hFE00,0,1,R01);
        add(0,0,0,16'hFE00,0,1,I01);
        // abort memory read in cycle 2
        add(0,1,0,16'h4000,0,1,I01);
        add(0,1,0,16'h4000,0,1,MEMR);
        add(0,0,0,16'h4000,0,1,I11);
        add(0,0,0,16'h4000,0,1,I11);
        add(0,0,0,16'h4000,0,1,I11);
        // reset in the middle of a memory write, then a full write
        add(0,1,1,16'h5000,0,1,I11);
        add(0,1,1,16'h5000,0,1,MEMW);
        add(1,1,1,16'h5000,0,1,MEMW);
        add(0,1,1,16'h5000,0,1,I11);
        add(0,1,1,16'h5000,0,1,MEMW);
        add(0,1,1,16'h5000,0,1,MEMW);
        add(0,1,1,16'h5000,0,1,MEMW);
        add(0,1,1,16'h5000,0,1,R11);
        add(0,0,0,16'h5000,0,1,I11);
        // KBSR, DSR, KBDR writes
        add(0,1,1,16'hFE00,0,1,I11);
        add(0,1,1,16'hFE00,0,1,WKBSR);
        add(0,1,1,16'hFE00,0,1,R01);
        add(0,0,0,16'hFE00,0,1,I01);
        add(0,1,1,16'hFE04,0,1,I01);
        add(0,1,1,16'hFE04,0,1,WDSR);
        add(0,1,1,16'hFE04,0,1,R10);
        add(0,0,0,16'hFE04,0,1,I10);
        add(0,1,1,16'hFE02,0,1,I10);
        add(0,1,1,16'hFE02,0,1,I00);
        add(0,1,1,16'hFE02,0,1,R00);
        add(0,0,0,16'hFE02,0,1,I00);
        // non-device xFExx is memory; MAR change after sample ignored
        add(0,1,0,16'hFE08,0,1,I00);
        add(0,1,0,16'hFE02,0,1,MEMR);
        add(0,1,1,16'hFE02,0,1,MEMR);
        add(0,1,1,16'hFE02,0,1,MEMR);
        add(0,1,1,16'hFE02,0,1,R11);
        add(0,0,0,16'hFE02,0,1,I11);
        // user-mode access to 0x0100
        add(0,1,0,16'h0100,1,1,I11);
`ifdef MEM_ACV_EN
        add(0,0,0,16'h0100,1,1,ACV11);
        add(0,0,0,16'h0100,1,1,I11);
        add(0,1,0,16'h0100,0,1,I11);
        add(0,1,0,16'h0100,0,1,MEMR);
        add(0,1,0,16'h0100,0,1,MEMR);
        add(0,1,0,16'h0100,0,1,MEMR);
        add(0,1,0,16'h0100,0,1,R11);
        add(0,0,0,16'h0100,0,1,I11);
`else
        add(0,1,0,16'h0100,1,1,MEMR);
        add(0,1,0,16'h0100,1,1,MEMR);
        add(0,1,0,16'h0100,1,1,MEMR);
        add(0,1,0,16'h0100,1,1,R11);
        add(0,0,0,16'h0100,1,1,I11);
`endif

        foreach (vq[i]) begin
            @(negedge CLK);
            RESET = vq[i].rst; bus.MIO_EN = vq[i].en; bus.R_W = vq[i].rw;
            bus.MAR = vq[i].mar; bus.PSR_15 = vq[i].psr;
            #1;
            if (vq[i].chk) check($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
        end

        // Held request: R latency, one-cycle R, bubble, then re-issue.
        @(negedge CLK);
        bus.MIO_EN = 1'b1; bus.R_W = 1'b0; bus.MAR = 16'h3100; bus.PSR_15 = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            #1;
        end while (!bus.R && n < 20);
        check("r_latency", 32'(n), 32'd4);
        @(negedge CLK); #1;
        check("bubble_r", 32'(bus.R), 32'd0);
        check("bubble_mem_en", 32'(bus.MEM_EN), 32'd0);
        @(negedge CLK); #1;
        check("reissue_mem_en", 32'(bus.MEM_EN), 32'd1);
        bus.MIO_EN = 1'b0;
        @(negedge CLK); #1;
        check("final_idle", 32'(outs()), 32'(I11));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
